// File: rtl/fetch_queue.sv
// Instruction prefetch buffer: sequential imem fetch into a small {pc, inst} FIFO feeding decode.
// Optional combinational imem-to-decode bypass when the FIFO is empty: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_en,
    output logic [13:0] imem_addr,
    input  logic [31:0] imem_dout,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]      fetch_pc_q,   fetch_pc_d;
    logic             pending_q,    pending_d;
    logic [31:0]      pending_pc_q, pending_pc_d;
    logic [PTR_W-1:0] wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,     rd_ptr_d;
    logic [CNT_W-1:0] count_q,      count_d;
    logic [31:0]      mem_pc_q   [DEPTH];
    logic [31:0]      mem_pc_d   [DEPTH];
    logic [31:0]      mem_inst_q [DEPTH];
    logic [31:0]      mem_inst_d [DEPTH];

    logic             issue;
    logic             head_avail;
    logic             bypass;
    logic             deq;
    logic             deq_fifo;
    logic             wr_en;
    logic [CNT_W:0]   occupancy;

    // Issue throttle counts the in-flight read so the FIFO can never overflow.
    always_comb begin
        occupancy  = {1'b0, count_q} + (CNT_W + 1)'(pending_q);
        issue      = !rst && !redirect_valid && (occupancy < (CNT_W + 1)'(DEPTH));
        head_avail = (count_q != '0);
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass     = !rst && !redirect_valid && !head_avail && pending_q;
`else
        bypass     = 1'b0;
`endif
    end

    // Decode-facing outputs; a redirect or reset hides the head in the same cycle.
    always_comb begin
        inst_valid = !rst && !redirect_valid && (head_avail || bypass);
        inst       = '0;
        inst_pc    = '0;
        if (head_avail) begin
            inst    = mem_inst_q[rd_ptr_q];
            inst_pc = mem_pc_q[rd_ptr_q];
        end else if (bypass) begin
            inst    = imem_dout;
            inst_pc = pending_pc_q;
        end
        deq       = inst_valid && inst_ready;
        deq_fifo  = deq && head_avail;
        wr_en     = pending_q && !redirect_valid && !(bypass && inst_ready);
        imem_en   = issue;
        imem_addr = fetch_pc_q[15:2];
        empty     = !head_avail && !pending_q;
    end

    // Next-state: fetch pointer, in-flight tracking and FIFO bookkeeping.
    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        pending_d    = issue;
        pending_pc_d = pending_pc_q;
        wr_ptr_d     = wr_ptr_q + PTR_W'(wr_en);
        rd_ptr_d     = rd_ptr_q + PTR_W'(deq_fifo);
        count_d      = count_q + CNT_W'(wr_en) - CNT_W'(deq_fifo);
        mem_pc_d     = mem_pc_q;
        mem_inst_d   = mem_inst_q;

        if (issue) begin
            pending_pc_d = fetch_pc_q;
            fetch_pc_d   = fetch_pc_q + 32'd4;
        end

        if (wr_en) begin
            mem_pc_d[wr_ptr_q]   = pending_pc_q;
            mem_inst_d[wr_ptr_q] = imem_dout;
        end

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
            pending_d  = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q   <= RESET_PC;
            pending_q    <= 1'b0;
            pending_pc_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            pending_q    <= pending_d;
            pending_pc_q <= pending_pc_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Payload storage needs no reset: it is only visible while count is non-zero.
    always_ff @(posedge clk) begin
        mem_pc_q   <= mem_pc_d;
        mem_inst_q <= mem_inst_d;
    end

endmodule
